// File: rtl/cw305_ml_sequencer.sv
// cw305_ml_sequencer: sequential single-layer neural network evaluator.
// One signed 8x8 MAC per cycle; each neuron takes pN_INPUTS MAC cycles plus
// one WRITE cycle, where a ReLU saturating at 127 produces the output byte.
module cw305_ml_sequencer #(
    parameter int pN_INPUTS  = 4,
    parameter int pN_OUTPUTS = 4,
    parameter int pACC_WIDTH = 20
) (
    input  logic                           usb_clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [pN_INPUTS*8-1:0]         inputs,
    input  logic [pN_INPUTS*pN_OUTPUTS*8-1:0] weights,
    input  logic [pN_OUTPUTS*8-1:0]        bias,
    output logic [pN_OUTPUTS*8-1:0]        outputs,
    output logic                           busy,
    output logic                           done,
    output logic                           trigger
);

    localparam int IW = (pN_INPUTS  > 1) ? $clog2(pN_INPUTS)  : 1;
    localparam int JW = (pN_OUTPUTS > 1) ? $clog2(pN_OUTPUTS) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(pN_INPUTS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(pN_OUTPUTS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

    state_t state, state_nxt;

    logic [IW-1:0]                i_idx;
    logic [JW-1:0]                j_idx;
    logic signed [pACC_WIDTH-1:0] acc;

    // Snapshot of the operands, so the host may change its ports mid-run.
    logic signed [7:0] in_r [pN_INPUTS];
    logic signed [7:0] w_r  [pN_OUTPUTS][pN_INPUTS];
    logic signed [7:0] b_r  [pN_OUTPUTS];

    logic signed [15:0] prod;
    logic               i_last;
    logic               j_last;

    assign i_last  = (i_idx == I_LAST);
    assign j_last  = (j_idx == J_LAST);
    assign prod    = in_r[i_idx] * w_r[j_idx][i_idx];
    assign trigger = busy;

    // ReLU with saturation to the positive int8 range.
    function automatic logic [7:0] relu_sat(input logic signed [pACC_WIDTH-1:0] a);
        if (a < 0)
            return 8'd0;
        else if (a > pACC_WIDTH'(127))
            return 8'd127;
        else
            return a[7:0];
    endfunction

    // State register; reset wins over any transition.
    always_ff @(posedge usb_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD:  state_nxt = MAC;
            MAC:   if (i_last) state_nxt = WRITE;
            WRITE: state_nxt = j_last ? DONE : MAC;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand snapshot, accumulate, write back one byte per neuron.
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            outputs <= '0;
            acc     <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
            for (int i = 0; i < pN_INPUTS; i++) in_r[i] <= '0;
            for (int j = 0; j < pN_OUTPUTS; j++) begin
                b_r[j] <= '0;
                for (int i = 0; i < pN_INPUTS; i++) w_r[j][i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    for (int i = 0; i < pN_INPUTS; i++) in_r[i] <= inputs[i*8 +: 8];
                    for (int j = 0; j < pN_OUTPUTS; j++) begin
                        b_r[j] <= bias[j*8 +: 8];
                        for (int i = 0; i < pN_INPUTS; i++)
                            w_r[j][i] <= weights[(j*pN_INPUTS+i)*8 +: 8];
                    end
                    i_idx <= '0;
                    j_idx <= '0;
                    acc   <= pACC_WIDTH'($signed(bias[7:0]));
                end
                MAC: begin
                    acc <= acc + pACC_WIDTH'(prod);
                    if (!i_last) i_idx <= i_idx + 1'b1;
                end
                WRITE: begin
                    outputs[{j_idx, 3'b000} +: 8] <= relu_sat(acc);
                    if (!j_last) begin
                        j_idx <= j_idx + 1'b1;
                        i_idx <= '0;
                        acc   <= pACC_WIDTH'(b_r[j_idx + 1'b1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cw305_ml_sequencer.md
CW305_ML_SEQUENCER -- requirements
Module: cw305_ml_sequencer

Interface
REQ-001 Parameter pN_INPUTS, 4, number of neuron inputs (>=1).
REQ-002 Parameter pN_OUTPUTS, 4, number of neurons/outputs (>=1).
REQ-003 Parameter pACC_WIDTH, 20, signed accumulator width; SHALL be >= 16+clog2(pN_INPUTS+1)+1.
REQ-004 usb_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request one layer evaluation; sampled only in IDLE.
REQ-007 inputs  input  pN_INPUTS*8  signed 8-bit activations; input i at [i*8 +: 8].
REQ-008 weights  input  pN_INPUTS*pN_OUTPUTS*8  signed 8-bit weights; w[j][i] at [(j*pN_INPUTS+i)*8 +: 8].
REQ-009 bias  input  pN_OUTPUTS*8  signed 8-bit bias; output j at [j*8 +: 8].
REQ-010 outputs  output  pN_OUTPUTS*8  unsigned 8-bit results; output j at [j*8 +: 8].
REQ-011 busy  output  1  high while an evaluation is in progress.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 trigger  output  1  scope capture trigger; equals busy.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, MAC, WRITE, DONE.
REQ-015 IDLE -> LOAD on the edge sampling start=1; otherwise remain IDLE.
REQ-016 LOAD (1 cycle): snapshot inputs, weights, bias into internal registers; output index j=0, input index i=0; acc = sign-extended bias[0]; -> MAC.
REQ-017 MAC (one cycle per input): acc += sext(in[i])*sext(w[j][i]) (signed 8x8 -> 16-bit product, sign-extended to pACC_WIDTH); after i=pN_INPUTS-1 -> WRITE, else i+1.
REQ-018 WRITE (1 cycle): outputs[j] <= activation(acc); if j=pN_OUTPUTS-1 -> DONE, else j+1, i=0, acc = sext(bias[j+1]), -> MAC.
REQ-019 activation: acc<0 -> 0; acc>127 -> 127; else acc[7:0] (ReLU, saturate to 127).
REQ-020 DONE (1 cycle): done=1; -> IDLE.
REQ-021 done SHALL be high exactly one cycle, 2+pN_OUTPUTS*(pN_INPUTS+1) edges after the edge sampling start (22 for defaults).
REQ-022 busy SHALL be 1 in LOAD, MAC, WRITE, DONE; 0 in IDLE.
REQ-023 start while busy SHALL be ignored (no queuing, no restart).
REQ-024 start held high continuously SHALL begin a new evaluation on the edge after DONE (back-to-back, one IDLE cycle between).
REQ-025 Changes to inputs/weights/bias after LOAD SHALL NOT affect the running evaluation.
REQ-026 outputs[j] SHALL update only in WRITE for that j; all other bytes hold; outputs hold indefinitely in IDLE.
REQ-027 No arithmetic wrap: accumulator width per REQ-003 guarantees exact sum.

Reset
REQ-028 rst=1 SHALL on the next edge force IDLE, outputs=0, busy=0, done=0, trigger=0, acc=0, indices=0, regardless of state.
REQ-029 rst asserted mid-evaluation SHALL abort it with no done pulse; partial outputs cleared to 0.
REQ-030 rst has priority over start on the same edge.

Verification
REQ-031 All inputs=1, all weights=1, bias=0, start pulse -> done at edge 22, outputs=0x04040404, busy high edges 1..22.
REQ-032 inputs=127 each, weights=127 each, bias=127 -> all outputs=127 (saturation); inputs=-128, weights=127, bias=0 -> all outputs=0 (ReLU).
REQ-033 inputs={1,2,3,4}, w[j][i]=j+1, bias[j]=-5 -> outputs={5,15,25,35} (byte 0 = 5).
REQ-034 Change weights to 0 at edge 5 after start and pulse start at edge 10 -> results per original weights, single done at edge 22, second start ignored.
REQ-035 rst at edge 12 after start -> no done, outputs=0, busy=0 next cycle; following start completes normally.
REQ-036 start held high for 60 cycles -> done pulses at edges 22 and 45, busy low for exactly one cycle between runs.
